// File: rtl/input_frame_ctrl_if.sv
// Stream bundle for input_frame_ctrl: sample input handshake plus framed
// output handshake. Signal prefixes are relative to the framer block.
interface input_frame_ctrl_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] i_data;
  logic              i_data_valid;
  logic              o_data_ready;
  logic [DATA_W-1:0] o_data;
  logic              o_data_valid;
  logic              o_data_last;
  logic              i_data_ready;

  // Framer side
  modport slave (
    input  i_data, i_data_valid, i_data_ready,
    output o_data_ready, o_data, o_data_valid, o_data_last
  );

  // Host / FFT side driving the framer
  modport master (
    output i_data, i_data_valid, i_data_ready,
    input  o_data_ready, o_data, o_data_valid, o_data_last
  );
endinterface

// File: rtl/input_frame_ctrl.sv
// Overlapping-frame builder in front of the FFT core. Samples are written
// into a FRAME_LEN-deep circular buffer; once FRAME_LEN (first frame) or HOP
// (later frames) new samples have arrived, the whole window is read out
// oldest-first. A registered RAM read feeds a one-entry output register; the
// RAM read register doubles as the skid slot, since a read is only issued
// when there is guaranteed room for its result.
module input_frame_ctrl #(
  parameter int DATA_W    = 32,
  parameter int FRAME_LEN = 128,
  parameter int HOP       = 64,
  parameter int ADDR_W    = 7
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input_frame_ctrl_if.slave   bus,
  output logic [15:0]         o_frame_cnt
);

  typedef enum logic [1:0] {
    S_PRIME,
    S_EMIT,
    S_HOP
  } state_t;

  localparam logic [ADDR_W:0] PRIME_LAST = (ADDR_W+1)'(FRAME_LEN - 1);
  localparam logic [ADDR_W:0] HOP_LAST   = (ADDR_W+1)'(HOP - 1);
  localparam logic [ADDR_W:0] FRAME_SZ   = (ADDR_W+1)'(FRAME_LEN);

  state_t            r_state;
  logic [DATA_W-1:0] r_mem [FRAME_LEN];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_in_cnt;
  logic [ADDR_W:0]   r_issue_cnt;
  logic [DATA_W-1:0] r_q;
  logic              r_q_vld;
  logic              r_q_last;
  logic [DATA_W-1:0] r_out;
  logic              r_out_vld;
  logic              r_out_last;
  logic              r_ready;
  logic [15:0]       r_frame_cnt;

  logic w_in_acc;
  logic w_in_last;
  logic w_out_take;
  logic w_out_load;
  logic w_issue;

  // Handshake qualifiers and read-pipeline flow control
  always_comb begin
    w_in_acc   = bus.i_data_valid & r_ready;
    w_in_last  = (r_state == S_PRIME) ? (r_in_cnt == PRIME_LAST)
                                      : (r_in_cnt == HOP_LAST);
    w_out_take = r_out_vld & bus.i_data_ready;
    w_out_load = r_q_vld & (~r_out_vld | w_out_take);
    w_issue    = (r_state == S_EMIT) & (r_issue_cnt != FRAME_SZ)
               & (~r_q_vld | w_out_load);
  end

  // Sample buffer: write on input accept, registered read on issue
  always_ff @(posedge i_clk) begin
    if (w_in_acc) begin
      r_mem[r_wr_ptr] <= bus.i_data;
    end
    if (w_issue) begin
      r_q <= r_mem[r_rd_ptr];
    end
  end

  // Frame FSM, pointers, read pipeline valids and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_PRIME;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_in_cnt    <= '0;
      r_issue_cnt <= '0;
      r_q_vld     <= 1'b0;
      r_q_last    <= 1'b0;
      r_out       <= '0;
      r_out_vld   <= 1'b0;
      r_out_last  <= 1'b0;
      r_ready     <= 1'b1;
      r_frame_cnt <= '0;
    end else begin
      if (w_in_acc) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end

      if (w_issue) begin
        r_rd_ptr    <= r_rd_ptr + 1'b1;
        r_issue_cnt <= r_issue_cnt + 1'b1;
        r_q_vld     <= 1'b1;
        r_q_last    <= (r_issue_cnt == PRIME_LAST);
      end else if (w_out_load) begin
        r_q_vld <= 1'b0;
      end

      if (w_out_load) begin
        r_out      <= r_q;
        r_out_last <= r_q_last;
        r_out_vld  <= 1'b1;
      end else if (w_out_take) begin
        r_out_vld  <= 1'b0;
        r_out_last <= 1'b0;
      end

      case (r_state)
        S_PRIME, S_HOP: begin
          if (w_in_acc) begin
            if (w_in_last) begin
              // Oldest entry sits just past the sample being written now
              r_state     <= S_EMIT;
              r_ready     <= 1'b0;
              r_in_cnt    <= '0;
              r_issue_cnt <= '0;
              r_rd_ptr    <= r_wr_ptr + 1'b1;
            end else begin
              r_in_cnt <= r_in_cnt + 1'b1;
            end
          end
        end
        S_EMIT: begin
          if (w_out_take && r_out_last) begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
            r_state     <= S_HOP;
            r_ready     <= 1'b1;
          end
        end
        default: begin
          r_state <= S_PRIME;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.o_data_ready = r_ready;
  assign bus.o_data       = r_out;
  assign bus.o_data_valid = r_out_vld;
  assign bus.o_data_last  = r_out_last;
  assign o_frame_cnt      = r_frame_cnt;

endmodule

// File: tb/tb_input_frame_ctrl.sv
// Scoreboard bench for input_frame_ctrl: a reference window model pushes the
// expected frames when input accepts complete a hop, and a monitor pops and
// compares every output transfer. A second 16/16 instance covers HOP=FRAME_LEN.
module tb_input_frame_ctrl;
  localparam int DW  = 32;
  localparam int FL  = 128;
  localparam int HP  = 64;
  localparam int AW  = 7;
  localparam int FL2 = 16;

  typedef struct {
    logic [31:0] d;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst2 = 1'b1;
  logic [15:0] frame_cnt;
  logic [15:0] frame_cnt2;
  int ready_mode = 0;

  int n_tests = 0;
  int n_fail  = 0;

  exp_t        exp_q[$];
  exp_t        exp2_q[$];
  logic [31:0] hist[$];
  exp_t        e;
  exp_t        e2;
  int          out_idx = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic        prev_last;
  logic        prev_nonlast_xfer = 1'b0;

  always #5 clk = ~clk;

  input_frame_ctrl_if #(.DATA_W(DW)) bus ();
  input_frame_ctrl_if #(.DATA_W(DW)) bus2 ();

  input_frame_ctrl #(.DATA_W(DW), .FRAME_LEN(FL), .HOP(HP), .ADDR_W(AW)) dut (
    .i_clk(clk), .i_rst(rst), .bus(bus.slave), .o_frame_cnt(frame_cnt)
  );

  input_frame_ctrl #(.DATA_W(DW), .FRAME_LEN(FL2), .HOP(FL2), .ADDR_W(4)) dut2 (
    .i_clk(clk), .i_rst(rst2), .bus(bus2.slave), .o_frame_cnt(frame_cnt2)
  );

  // Downstream ready: held high or ~50% random
  always @(posedge clk) begin
    #1;
    bus.i_data_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
  end

  // Model + scoreboard for the main instance
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      hist.delete();
      out_idx = 0;
      prev_stall = 1'b0;
      prev_nonlast_xfer = 1'b0;
    end else begin
      if (prev_stall) begin
        n_tests++;
        if (bus.o_data_valid !== 1'b1 || bus.o_data !== prev_data || bus.o_data_last !== prev_last) begin
          n_fail++;
          $display("FAIL stall_hold: valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
                   bus.o_data_valid, bus.o_data, bus.o_data_last, prev_data, prev_last);
        end
      end
      if (prev_nonlast_xfer) begin
        n_tests++;
        if (bus.o_data_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL no_bubble: valid=%b, required 1", bus.o_data_valid);
        end
      end
      if (bus.o_data_valid === 1'b1) begin
        n_tests++;
        if (bus.o_data_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL ready_in_emit: ready=%b, required 0", bus.o_data_ready);
        end
      end else if (exp_q.size() == 0) begin
        n_tests++;
        if (bus.o_data_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL ready_idle: ready=%b, required 1", bus.o_data_ready);
        end
      end
      if (bus.i_data_valid === 1'b1 && bus.o_data_ready === 1'b1) begin
        hist.push_back(bus.i_data);
        if (hist.size() == FL || (hist.size() > FL && (hist.size() - FL) % HP == 0)) begin
          for (int i = 0; i < FL; i++)
            exp_q.push_back(exp_t'{hist[hist.size() - FL + i], (i == FL - 1)});
        end
      end
      if (bus.o_data_valid === 1'b1 && bus.i_data_ready === 1'b1) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_output: data=%h last=%b, required no output",
                   bus.o_data, bus.o_data_last);
        end else begin
          e = exp_q.pop_front();
          if (bus.o_data !== e.d || bus.o_data_last !== e.last) begin
            n_fail++;
            $display("FAIL out_data: data=%h last=%b, required data=%h last=%b",
                     bus.o_data, bus.o_data_last, e.d, e.last);
          end
          out_idx = e.last ? 0 : out_idx + 1;
        end
      end
      prev_stall        = (bus.o_data_valid === 1'b1) && (bus.i_data_ready !== 1'b1);
      prev_data         = bus.o_data;
      prev_last         = bus.o_data_last;
      prev_nonlast_xfer = (bus.o_data_valid === 1'b1) && (bus.i_data_ready === 1'b1)
                        && (bus.o_data_last !== 1'b1);
    end
  end

  // Scoreboard for the HOP=FRAME_LEN instance
  always @(negedge clk) begin
    if (!rst2 && bus2.o_data_valid === 1'b1 && bus2.i_data_ready === 1'b1) begin
      n_tests++;
      if (exp2_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output2: data=%h, required no output", bus2.o_data);
      end else begin
        e2 = exp2_q.pop_front();
        if (bus2.o_data !== e2.d || bus2.o_data_last !== e2.last) begin
          n_fail++;
          $display("FAIL out_data2: data=%h last=%b, required data=%h last=%b",
                   bus2.o_data, bus2.o_data_last, e2.d, e2.last);
        end
      end
    end
  end

  task automatic send(input logic [31:0] d);
    int unsigned g = 0;
    bus.i_data = d;
    bus.i_data_valid = 1'b1;
    @(negedge clk);
    while (bus.o_data_ready !== 1'b1 && g < 2000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 2000) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: ready=%b after %0d cycles, required 1", bus.o_data_ready, g);
    end
    @(posedge clk);
    #1;
    bus.i_data_valid = 1'b0;
  endtask

  task automatic send_gap(input logic [31:0] d);
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk);
      #1;
    end
    send(d);
  endtask

  task automatic send2(input logic [31:0] d);
    int unsigned g = 0;
    bus2.i_data = d;
    bus2.i_data_valid = 1'b1;
    exp2_q.push_back(exp_t'{d, (d % FL2 == FL2 - 1)});
    @(negedge clk);
    while (bus2.o_data_ready !== 1'b1 && g < 2000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 2000) begin
      n_tests++;
      n_fail++;
      $display("FAIL send2_timeout: ready=%b, required 1", bus2.o_data_ready);
    end
    @(posedge clk);
    #1;
    bus2.i_data_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int unsigned g = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || bus.o_data_valid !== 1'b0) && g < 5000) begin
      @(negedge clk);
      g++;
    end
    n_tests++;
    if (g >= 5000) begin
      n_fail++;
      $display("FAIL drain_timeout: pending=%0d valid=%b, required 0 and 0",
               exp_q.size(), bus.o_data_valid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_cnt(input string name, input logic [15:0] req);
    n_tests++;
    if (frame_cnt !== req) begin
      n_fail++;
      $display("FAIL %s: frame_cnt=%0d, required %0d", name, frame_cnt, req);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (bus.o_data_valid !== 1'b0 || bus.o_data_last !== 1'b0 || bus.o_data_ready !== 1'b1 || frame_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b last=%b ready=%b cnt=%0d, required 0 0 1 0",
               bus.o_data_valid, bus.o_data_last, bus.o_data_ready, frame_cnt);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_first_frame();
    logic [2:0] lat;
    ready_mode = 0;
    for (int i = 0; i < FL; i++) send(32'(i));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      lat[c] = bus.o_data_valid;
    end
    n_tests++;
    if (lat !== 3'b100) begin
      n_fail++;
      $display("FAIL first_latency: valid per cycle (c2c1c0)=%b, required 100", lat);
    end
    @(posedge clk);
    #1;
    wait_drain();
    check_cnt("first_frame_cnt", 16'd1);
  endtask

  task automatic test_hop_frames();
    for (int i = FL; i < 2 * FL; i++) send(32'(i));
    wait_drain();
    check_cnt("hop_frame_cnt", 16'd3);
  endtask

  task automatic test_backpressure();
    ready_mode = 1;
    for (int i = 2 * FL; i < 2 * FL + 3 * HP; i++) send(32'(i));
    wait_drain();
    ready_mode = 0;
    check_cnt("backpressure_frame_cnt", 16'd6);
  endtask

  task automatic test_input_gaps();
    for (int i = 2 * FL + 3 * HP; i < 2 * FL + 6 * HP; i++) send_gap(32'(i));
    wait_drain();
    check_cnt("gaps_frame_cnt", 16'd9);
  endtask

  task automatic test_reset_midframe();
    int unsigned g = 0;
    logic seen_valid = 1'b0;
    test_reset();
    for (int i = 0; i < FL + HP; i++) send(32'(i));
    while (!(frame_cnt == 16'd1 && out_idx == 40) && g < 2000) begin
      @(negedge clk);
      g++;
    end
    n_tests++;
    if (g >= 2000) begin
      n_fail++;
      $display("FAIL midframe_wait: out_idx=%0d cnt=%0d, required 40 and 1", out_idx, frame_cnt);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bus.o_data_valid !== 1'b0 || frame_cnt !== 16'd0 || bus.o_data_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midframe_reset: valid=%b cnt=%0d ready=%b, required 0 0 1",
               bus.o_data_valid, frame_cnt, bus.o_data_ready);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < FL - 1; i++) send(32'(1000 + i));
    repeat (4) begin
      @(negedge clk);
      seen_valid = seen_valid | (bus.o_data_valid === 1'b1);
    end
    n_tests++;
    if (seen_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL partial_no_output: valid seen=%b, required 0", seen_valid);
    end
    @(posedge clk);
    #1;
    send(32'(1000 + FL - 1));
    wait_drain();
    check_cnt("fresh_frame_cnt", 16'd1);
  endtask

  task automatic test_hop_eq_frame();
    int unsigned g = 0;
    rst2 = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3 * FL2; i++) send2(32'(i));
    while ((exp2_q.size() != 0 || bus2.o_data_valid !== 1'b0) && g < 2000) begin
      @(negedge clk);
      g++;
    end
    n_tests++;
    if (g >= 2000 || frame_cnt2 !== 16'd3) begin
      n_fail++;
      $display("FAIL hop_eq_frame: pending=%0d cnt=%0d, required 0 and 3", exp2_q.size(), frame_cnt2);
    end
  endtask

  initial begin
    bus.i_data = '0;
    bus.i_data_valid = 1'b0;
    bus2.i_data = '0;
    bus2.i_data_valid = 1'b0;
    bus2.i_data_ready = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_first_frame();
    test_hop_frames();
    test_backpressure();
    test_input_gaps();
    test_reset_midframe();
    test_hop_eq_frame();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/input_frame_ctrl.md
Name: input_frame_ctrl

Overview:
Front-end framer for the FFT datapath. Accepts a continuous stream of 32-bit samples from the host-side stream interface and emits overlapping frames of FRAME_LEN samples, advancing HOP new samples per frame. It feeds the FFT core and is the counterpart of the output overlap-add stage. Internal circular buffer, one clock domain.

Parameters:
DATA_W, 32, sample width in bits.
FRAME_LEN, 128, samples per emitted frame; power of two, >= 4.
HOP, 64, new samples per frame after the first; 1 <= HOP <= FRAME_LEN.
ADDR_W, 7, log2(FRAME_LEN).

Ports:
i_clk  in  1  clock; all logic on rising edge.
i_rst  in  1  synchronous reset, active-high.
i_data  in  DATA_W  input sample.
i_data_valid  in  1  input sample valid.
o_data_ready  out  1  block can accept a sample.
o_data  out  DATA_W  framed output sample.
o_data_valid  out  1  output sample valid.
o_data_last  out  1  marks the last sample (index FRAME_LEN-1) of a frame.
i_data_ready  in  1  downstream accepts the output sample.
o_frame_cnt  out  16  count of frames fully emitted; wraps at 2^16.

Behaviour:
- Reset (synchronous, active-high; all outputs below apply at the edge after i_rst is sampled high):
  - o_data_valid, o_data_last = 0.
  - o_frame_cnt = 0.
  - o_data_ready = 1.
  - State = PRIME; write pointer and counters = 0.
  - Buffer RAM is not cleared; it is treated as empty.
  - Reset mid-frame aborts the frame. No partial frame continues afterwards.
- Input handshake: a sample is accepted on an edge where i_data_valid & o_data_ready.
  - It is written to mem[wr_ptr]; wr_ptr increments and wraps FRAME_LEN-1 -> 0.
- Output handshake: a sample is transferred on an edge where o_data_valid & i_data_ready.
  - While o_data_valid=1 and i_data_ready=0, o_data and o_data_last hold stable.
  - o_data_valid never drops without a transfer, except on reset.
- State machine:
  - PRIME: o_data_ready=1. Counts FRAME_LEN accepted samples. The accept of sample FRAME_LEN-1 moves to EMIT.
  - EMIT: o_data_ready=0. Reads FRAME_LEN samples oldest-first, starting at rd_ptr = wr_ptr (the oldest entry), incrementing with wrap.
    - o_data_last=1 only with the FRAME_LEN-th sample.
    - The transfer of that last sample increments o_frame_cnt and moves to HOP.
  - HOP: o_data_ready=1. Counts HOP accepted samples. The accept of the HOP-th sample moves to EMIT.
  - Net result: frame k (k >= 1) contains input samples k*HOP .. k*HOP+FRAME_LEN-1.
- Latency:
  - The first o_data_valid of a frame is asserted exactly 2 cycles after the edge that accepted the frame-completing input sample (address issue plus registered RAM read).
  - Within a frame with i_data_ready held high, o_data_valid stays high continuously: one sample per cycle, no bubbles. A skid/prefetch register is required to meet this under back-pressure.
- After the last transfer of a frame:
  - o_data_valid=0 on the next cycle, unless HOP input completes first. It cannot: o_data_ready rises only on the cycle after the last transfer.
  - o_data_ready=1 from the edge after the last output transfer.
- Simultaneous events: input and output are never active in the same cycle by construction, since o_data_ready=0 in EMIT.
- HOP=FRAME_LEN: non-overlapping frames. HOP=1: sliding window, one new sample per frame.
- o_frame_cnt wraps 65535 -> 0 silently.
- No arithmetic on data. Samples pass bit-exact.

Test Plan:
1. Reset, then feed 0..127 continuously, i_data_ready=1 -> valid rises 2 cycles after sample 127 accepted; outputs 0..127 on consecutive cycles; last with 127; o_frame_cnt=1; o_data_ready=0 throughout EMIT.
2. Continue feeding 128..191 -> frame 1 = 64..191, last with 191, o_frame_cnt=2. Feed 192..255 -> frame 2 = 128..255.
3. Random i_data_ready (about 50% duty) over 3 frames -> exact sequences as in 2; no drop or duplicate; o_data stable while stalled.
4. Random i_data_valid gaps on input -> identical output frames; o_data_ready low only during EMIT.
5. Assert i_rst for 1 cycle during sample 40 of frame 1 -> o_data_valid=0 and o_frame_cnt=0 next edge; 127 new samples produce no output; sample 128 starts a fresh frame of the new data only.
6. HOP=FRAME_LEN=16 build; feed 0..47 -> three frames 0..15, 16..31, 32..47; o_frame_cnt=3.
